// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register endpoint.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StDevAck,
        StRegAddr,
        StRegAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StWaitStop
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h50;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA, detects their edges and flags START/STOP conditions.
module i2c_bus_monitor
    import i2c_target_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_sync,
    output logic start,
    output logic stop
);

    // [0],[1] synchronizer stages, [2] history; reset to the idle-bus level
    logic [2:0] scl_p;
    logic [2:0] sda_p;
    logic       sda_rise;
    logic       sda_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_p <= 3'b111;
            sda_p <= 3'b111;
        end else begin
            scl_p <= {scl_p[1:0], scl};
            sda_p <= {sda_p[1:0], sda};
        end
    end

    always_comb begin
        scl_rise = scl_p[1] & ~scl_p[2];
        scl_fall = ~scl_p[1] & scl_p[2];
        sda_rise = sda_p[1] & ~sda_p[2];
        sda_fall = ~sda_p[1] & sda_p[2];
        sda_sync = sda_p[1];
        start    = sda_fall & scl_p[1];
        stop     = sda_rise & scl_p[1];
    end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file: register-pointer writes (with burst) and random reads.
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = DEF_DEV_ADDR,
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned REG_DEPTH = 2 ** REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    input  logic [REG_AW-1:0] host_raddr,
    output logic [7:0]        host_rdata,
    output logic              wr_strobe,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    state_t            state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [REG_AW-1:0] ptr;
    logic              sda_low;
    logic [7:0]        regs [REG_DEPTH];

    logic scl_rise, scl_fall, sda_in, start_det, stop_det;
    logic [7:0] rx_byte;

    i2c_bus_monitor u_bus_monitor (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_sync (sda_in),
        .start    (start_det),
        .stop     (stop_det)
    );

    assign sda        = sda_low ? 1'b0 : 1'bz;
    assign host_rdata = regs[host_raddr];
    assign rx_byte    = {shreg[6:0], sda_in};

    // bit_cnt == 8 marks a completed byte whose ACK/reload is due on the next scl_fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            sda_low   <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_det) begin
                state   <= StDevAddr;
                bit_cnt <= '0;
                sda_low <= 1'b0;
            end else if (stop_det) begin
                state   <= StIdle;
                bit_cnt <= '0;
                sda_low <= 1'b0;
                busy    <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    StDevAddr, StRegAddr, StWrData: begin
                        if (bit_cnt < 4'd8) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (bit_cnt == 4'd7) begin
                            if (state == StDevAddr && rx_byte[7:1] != DEV_ADDR) begin
                                state <= StIdle;
                                busy  <= 1'b0;
                            end
                            if (state == StRegAddr) ptr <= rx_byte[REG_AW-1:0];
                            if (state == StWrData) begin
                                wr_strobe  <= 1'b1;
                                wr_addr    <= ptr;
                                wr_data    <= rx_byte;
                                regs[ptr]  <= rx_byte;
                                ptr        <= ptr + REG_AW'(1);
                            end
                        end
                    end
                    StRdAck: begin
                        if (sda_in == ACK) begin
                            ptr     <= ptr + REG_AW'(1);
                            bit_cnt <= 4'd8;
                        end else begin
                            state <= StWaitStop;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    StDevAddr, StRegAddr, StWrData: begin
                        if (bit_cnt == 4'd8) begin
                            sda_low <= 1'b1;
                            bit_cnt <= '0;
                            if (state == StDevAddr) begin
                                state <= StDevAck;
                                busy  <= 1'b1;
                            end else if (state == StRegAddr) begin
                                state <= StRegAck;
                            end else begin
                                state <= StWrAck;
                            end
                        end
                    end
                    StDevAck: begin
                        // shreg[0] still holds the R/W bit of the address byte
                        if (shreg[0]) begin
                            shreg   <= regs[ptr];
                            sda_low <= ~regs[ptr][7];
                            state   <= StRdData;
                        end else begin
                            sda_low <= 1'b0;
                            state   <= StRegAddr;
                        end
                        bit_cnt <= '0;
                    end
                    StRegAck, StWrAck: begin
                        sda_low <= 1'b0;
                        bit_cnt <= '0;
                        state   <= StWrData;
                    end
                    StRdData: begin
                        if (bit_cnt == 4'd7) begin
                            sda_low <= 1'b0;
                            bit_cnt <= '0;
                            state   <= StRdAck;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shreg   <= {shreg[6:0], shreg[7]};
                            sda_low <= ~shreg[6];
                        end
                    end
                    StRdAck: begin
                        if (bit_cnt == 4'd8) begin
                            shreg   <= regs[ptr];
                            sda_low <= ~regs[ptr][7];
                            bit_cnt <= '0;
                            state   <= StRdData;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: a bit-banged I2C master exercises writes, reads, aborts and reset.
module tb_i2c_target_regs;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_low;
    logic [3:0] host_raddr;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    wire        sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_target_regs dut (
        .clk        (clk),
        .rst        (rst),
        .scl        (scl),
        .sda        (sda),
        .host_raddr (host_raddr),
        .host_rdata (host_rdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int strobe_cnt = 0;
    logic [3:0] s_addr [$];
    logic [7:0] s_data [$];

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            s_addr.push_back(wr_addr);
            s_data.push_back(wr_data);
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_start();
        m_low = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        m_low = 1'b1; wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic m_stop();
        m_low = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        m_low = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic m_bit(input logic b, output logic rd);
        m_low = ~b; wait_q();
        scl = 1'b1; wait_q();
        rd = sda;   wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic m_byte(input logic [7:0] b, input logic ack_bit,
                          output logic [7:0] rd, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            m_bit(b[i], r);
            rd[i] = r;
        end
        m_bit(ack_bit, ack);
    endtask

    task automatic test_reset();
        rst = 1'b1; scl = 1'b1; m_low = 1'b0; host_raddr = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (sda !== 1'b1) $display("FAIL reset_sda: got %b want 1", sda); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (wr_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", wr_strobe); else n_pass++;
        n_total++; if (wr_addr !== 4'd0) $display("FAIL reset_wr_addr: got %h want 0", wr_addr); else n_pass++;
        n_total++; if (wr_data !== 8'd0) $display("FAIL reset_wr_data: got %h want 0", wr_data); else n_pass++;
        host_raddr = 4'd3; #1;
        n_total++; if (host_rdata !== 8'd0) $display("FAIL reset_reg3: got %h want 00", host_rdata); else n_pass++;
    endtask

    task automatic test_write();
        logic [7:0] rd; logic a0, a1, a2; int base;
        base = strobe_cnt;
        m_start();
        m_byte(8'hA0, 1'b1, rd, a0);
        m_byte(8'h03, 1'b1, rd, a1);
        m_byte(8'hA5, 1'b1, rd, a2);
        n_total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL wr_acks: got %b want 000", {a0, a1, a2}); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL wr_busy_hi: got %b want 1", busy); else n_pass++;
        m_stop();
        n_total++; if (busy !== 1'b0) $display("FAIL wr_busy_lo: got %b want 0", busy); else n_pass++;
        n_total++; if (strobe_cnt - base !== 1) $display("FAIL wr_strobes: got %0d want 1", strobe_cnt - base); else n_pass++;
        if (strobe_cnt > base) begin
            n_total++; if (s_addr[base] !== 4'd3) $display("FAIL wr_addr: got %h want 3", s_addr[base]); else n_pass++;
            n_total++; if (s_data[base] !== 8'hA5) $display("FAIL wr_data: got %h want a5", s_data[base]); else n_pass++;
        end
        host_raddr = 4'd3; #1;
        n_total++; if (host_rdata !== 8'hA5) $display("FAIL wr_reg3: got %h want a5", host_rdata); else n_pass++;
    endtask

    task automatic test_random_read();
        logic [7:0] rd; logic a0, a1, a2, nack; int base;
        base = strobe_cnt;
        m_start();
        m_byte(8'hA0, 1'b1, rd, a0);
        m_byte(8'h03, 1'b1, rd, a1);
        m_start();
        m_byte(8'hA1, 1'b1, rd, a2);
        n_total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rd_acks: got %b want 000", {a0, a1, a2}); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL rd_busy_hi: got %b want 1", busy); else n_pass++;
        m_byte(8'hFF, 1'b1, rd, nack);
        n_total++; if (rd !== 8'hA5) $display("FAIL rd_data: got %h want a5", rd); else n_pass++;
        n_total++; if (nack !== 1'b1) $display("FAIL rd_nack_line: got %b want 1", nack); else n_pass++;
        m_stop();
        n_total++; if (sda !== 1'b1) $display("FAIL rd_sda_after_stop: got %b want 1", sda); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rd_busy_lo: got %b want 0", busy); else n_pass++;
        n_total++; if (strobe_cnt !== base) $display("FAIL rd_no_strobe: got %0d want %0d", strobe_cnt, base); else n_pass++;
    endtask

    task automatic test_wrong_addr();
        logic [7:0] rd; logic a0, a1, a2; int base;
        base = strobe_cnt;
        m_start();
        m_byte(8'hA2, 1'b1, rd, a0);
        n_total++; if (busy !== 1'b0) $display("FAIL na_busy: got %b want 0", busy); else n_pass++;
        m_byte(8'h03, 1'b1, rd, a1);
        m_byte(8'h77, 1'b1, rd, a2);
        m_stop();
        n_total++; if ({a0, a1, a2} !== 3'b111) $display("FAIL na_acks: got %b want 111", {a0, a1, a2}); else n_pass++;
        n_total++; if (strobe_cnt !== base) $display("FAIL na_no_strobe: got %0d want %0d", strobe_cnt, base); else n_pass++;
        host_raddr = 4'd3; #1;
        n_total++; if (host_rdata !== 8'hA5) $display("FAIL na_reg3: got %h want a5", host_rdata); else n_pass++;
    endtask

    task automatic test_burst_wrap();
        logic [7:0] rd; logic [3:0] acks; int base;
        base = strobe_cnt;
        m_start();
        m_byte(8'hA0, 1'b1, rd, acks[3]);
        m_byte(8'h0F, 1'b1, rd, acks[2]);
        m_byte(8'h11, 1'b1, rd, acks[1]);
        m_byte(8'h22, 1'b1, rd, acks[0]);
        m_stop();
        n_total++; if (acks !== 4'b0000) $display("FAIL bw_acks: got %b want 0000", acks); else n_pass++;
        n_total++; if (strobe_cnt - base !== 2) $display("FAIL bw_strobes: got %0d want 2", strobe_cnt - base); else n_pass++;
        if (strobe_cnt - base >= 2) begin
            n_total++; if ({s_addr[base], s_addr[base+1]} !== 8'hF0) $display("FAIL bw_addrs: got %h want f0", {s_addr[base], s_addr[base+1]}); else n_pass++;
            n_total++; if ({s_data[base], s_data[base+1]} !== 16'h1122) $display("FAIL bw_data: got %h want 1122", {s_data[base], s_data[base+1]}); else n_pass++;
        end
        host_raddr = 4'd15; #1;
        n_total++; if (host_rdata !== 8'h11) $display("FAIL bw_reg15: got %h want 11", host_rdata); else n_pass++;
        host_raddr = 4'd0; #1;
        n_total++; if (host_rdata !== 8'h22) $display("FAIL bw_reg0: got %h want 22", host_rdata); else n_pass++;
    endtask

    task automatic test_stop_abort();
        logic [7:0] rd; logic a0, a1, a2, r; int base;
        base = strobe_cnt;
        m_start();
        m_byte(8'hA0, 1'b1, rd, a0);
        m_byte(8'h05, 1'b1, rd, a1);
        m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r);
        m_stop();
        n_total++; if (strobe_cnt !== base) $display("FAIL ab_no_strobe: got %0d want %0d", strobe_cnt, base); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ab_busy: got %b want 0", busy); else n_pass++;
        host_raddr = 4'd5; #1;
        n_total++; if (host_rdata !== 8'h00) $display("FAIL ab_reg5_kept: got %h want 00", host_rdata); else n_pass++;
        m_start();
        m_byte(8'hA0, 1'b1, rd, a0);
        m_byte(8'h05, 1'b1, rd, a1);
        m_byte(8'h3C, 1'b1, rd, a2);
        m_stop();
        n_total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL ab_retry_acks: got %b want 000", {a0, a1, a2}); else n_pass++;
        n_total++; if (strobe_cnt - base !== 1) $display("FAIL ab_retry_strobe: got %0d want 1", strobe_cnt - base); else n_pass++;
        host_raddr = 4'd5; #1;
        n_total++; if (host_rdata !== 8'h3C) $display("FAIL ab_reg5: got %h want 3c", host_rdata); else n_pass++;
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] rd; logic r, a;
        logic [3:0] addrs [4] = '{4'd0, 4'd3, 4'd5, 4'd15};
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(((8'hA0 >> i) & 8'h01) != 8'h00, r);
        m_low = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        n_total++; if (sda !== 1'b0) $display("FAIL rs_ack_low: got %b want 0", sda); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL rs_busy_before: got %b want 1", busy); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (sda !== 1'b1) $display("FAIL rs_sda_release: got %b want 1", sda); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rs_busy: got %b want 0", busy); else n_pass++;
        foreach (addrs[k]) begin
            host_raddr = addrs[k]; #1;
            n_total++; if (host_rdata !== 8'h00) $display("FAIL rs_reg%0d: got %h want 00", addrs[k], host_rdata); else n_pass++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        m_start();
        m_byte(8'hA0, 1'b1, rd, a);
        m_byte(8'h07, 1'b1, rd, r);
        m_byte(8'h5A, 1'b1, rd, r);
        m_stop();
        host_raddr = 4'd7; #1;
        n_total++; if (host_rdata !== 8'h5A) $display("FAIL rs_recover_reg7: got %h want 5a", host_rdata); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_random_read();
        test_wrong_addr();
        test_burst_wrap();
        test_stop_abort();
        test_reset_mid_ack();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
I2C target (slave) endpoint with an internal byte-wide register file. It is the far end of the team's I2C master, supporting both master transaction types:
- Write: START, addr+W, register address, data, STOP.
- Random read: START, addr+W, register address, repeated START, addr+R, data, NACK, STOP.

The system clock oversamples SCL (nominal ≥24 clk per SCL period). A read-only host port exposes the register contents to the rest of the design.

Parameters:
DEV_ADDR, 7'h50, 7-bit target address matched against the address byte.
REG_AW, 4, register pointer width.
REG_DEPTH, 16, number of 8-bit registers (2**REG_AW).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
scl  input  1  I2C clock from the master.
sda  inout  1  I2C data; driven only as 1'b0 or 1'bz (open-drain, external pull-up).
host_raddr  input  REG_AW  host read address.
host_rdata  output  8  regs[host_raddr], combinational.
wr_strobe  output  1  one-clk pulse for each I2C data byte written.
wr_addr  output  REG_AW  register written, valid with wr_strobe.
wr_data  output  8  byte written, valid with wr_strobe.
busy  output  1  high from an addressed START until STOP or abort.

Behaviour:
- Reset (async, rst=1):
  - sda released (z); all regs = 0; ptr = 0; state = IDLE.
  - wr_strobe = 0, wr_addr = 0, wr_data = 0, busy = 0.
  - Reset mid-transfer releases sda immediately.
- Input conditioning:
  - scl and sda each pass a 2-flop synchronizer plus a history flop.
  - Edge detect: scl_rise, scl_fall, sda_rise, sda_fall.
  - Total latency is 3 clk.
- Bus events:
  - START: sda_fall while synced scl = 1.
  - STOP: sda_rise while synced scl = 1.
  - Data is sampled on scl_rise.
  - The target changes its sda drive only on scl_fall, so it never makes an edge while SCL is high.
- States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- Transitions:
  - START in any state → DEV_ADDR, bit count = 0, ptr kept. This covers repeated START.
  - STOP in any state → IDLE, sda released, busy = 0. A partial byte is discarded with no write.
  - DEV_ADDR: shift 8 bits MSB first.
    - addr[7:1] == DEV_ADDR: on next scl_fall drive sda = 0 (ACK), go to DEV_ACK, busy = 1.
    - Mismatch: go to IDLE with no ACK (sda stays z).
  - DEV_ACK: on the following scl_fall, release sda.
    - R/W = 0 → REG_ADDR.
    - R/W = 1 → load shifter from regs[ptr], drive bit7 (0 → drive low, 1 → z), go to RD_DATA.
  - REG_ADDR: 8 bits, ptr = byte[REG_AW-1:0] (upper bits ignored); ACK, then REG_ACK → WR_DATA.
  - WR_DATA: 8 bits, then ACK.
    - On the 8th scl_rise: wr_strobe pulses, wr_addr = ptr, wr_data = byte, regs[ptr] updated.
    - ptr then increments mod REG_DEPTH (15 → 0).
    - WR_ACK → WR_DATA for burst writes.
  - RD_DATA:
    - Drive bits 6..0 on successive scl_falls.
    - After the 8th bit's scl_fall, release sda and go to RD_ACK.
  - RD_ACK: sample sda on scl_rise.
    - 0 (ACK): ptr++ (wrap), reload shifter on next scl_fall, go to RD_DATA.
    - 1 (NACK): go to WAIT_STOP with sda released.
  - WAIT_STOP: ignore everything except START/STOP.
- ACK drive:
  - Held from the scl_fall after bit 8 to the next scl_fall, i.e. one full SCL period low.
  - Valid at the master's mid-high sample point.
- While the target drives sda low, START/STOP detection is still active. Self-generated edges occur only with SCL low, so they never match.
- host_rdata reflects the same-cycle register write (write-first not required; the old value is acceptable on the strobe cycle).

Decomposition:
- Package i2c_target_pkg:
  - State enum encoding, 4 bits.
  - ACK/NACK constants.
  - Default DEV_ADDR.
- One sub-module, i2c_bus_monitor: synchronizers, edge detect, START/STOP pulses.
- The FSM and register file stay in the top module.

Test Plan:
1. Master write dev 0x50, reg 0x03, data 0xA5 → three ACKs on sda; wr_strobe once with wr_addr = 3, wr_data = 0xA5; host_rdata(3) = 0xA5; busy falls after STOP.
2. Random read:
   - Preload reg 3 = 0xA5.
   - Send write 0x50/0x03, repeated START, 0xA1.
   - Expect: sda carries 1,0,1,0,0,1,0,1; master NACK → WAIT_STOP; no wr_strobe; sda z after STOP.
3. Address 0x51 write → no ACK on any byte (sda z throughout), no wr_strobe, busy stays 0, regs unchanged.
4. Burst write reg 0x0F with data 0x11, 0x22 → regs[15] = 0x11, regs[0] = 0x22 (wrap); two strobes with wr_addr 15 then 0.
5. STOP after 3 data bits of the write byte → IDLE, no strobe, register unchanged; next full transaction succeeds.
6. Assert rst during the ACK low phase → sda z within 1 clk (asynchronous); all regs = 0; busy = 0.
